// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- iterative multiply/divide sequencer for the EX stage.
//
// Executes MULT, MULTU, DIV and DIVU over several cycles and owns HI/LO.
// Signed operands are converted to magnitudes in PREP and the signs are put
// back in FIXUP. busy stalls the front of the pipe while an op is in flight.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   defined   : MULT/MULTU leave CALC once the remaining multiplier is zero
//   undefined : CALC always runs XLEN iterations
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   issue op (sampled only in IDLE)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   in   rs / rt operands
//   flush  in   abort in-flight op
//   hi_we  in   MTHI enable
//   lo_we  in   MTLO enable
//   wdata  in   MTHI/MTLO data
//   busy   out  high in PREP, CALC, FIXUP
//   done   out  one-cycle pulse when an op updates HI/LO
//   hi, lo out  HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_CALC  = 2'd2,
        S_FIXUP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   ONE_W    = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2W   = (2*XLEN)'(1);

    // Two's-complement magnitude; only applied when the op is signed.
    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic is_signed);
        if (is_signed && v[XLEN-1]) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic                r_sign_q;
    logic                r_sign_r;
    // Multiply: product. Divide: {remainder, dividend/quotient shift register}.
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    // Multiply: remaining multiplier. Divide: divisor magnitude.
    logic [XLEN-1:0]     r_y;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_busy;
    logic                r_done;

    logic                w_is_div;
    logic                w_is_signed;
    logic                w_calc_last;
    logic                w_accept;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [XLEN:0]       w_div_sh;
    logic [XLEN:0]       w_div_diff;

    assign w_is_div    = r_op[1];
    assign w_is_signed = ~r_op[0];
    assign w_accept    = start & ~flush;
    assign w_abs_a     = f_abs(r_a, w_is_signed);
    assign w_abs_b     = f_abs(r_b, w_is_signed);
    // Remainder shifted left with the next dividend bit, then trial-subtract.
    assign w_div_sh    = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_sh - {1'b0, r_y};

`ifdef MULDIV_EARLY_OUT_EN
    // Multiply stops on the iteration that consumes the last set multiplier bit.
    assign w_calc_last = (r_cnt == CNT_LAST) || (!w_is_div && (r_y[XLEN-1:1] == '0));
`else
    assign w_calc_last = (r_cnt == CNT_LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush aborts any busy state back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PREP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PREP: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_calc_last) begin
                    w_state_nxt = S_FIXUP;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_FIXUP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            r_op <= op;
                            r_a  <= a;
                            r_b  <= b;
                        end
                    end else begin
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_PREP: begin
                    // Divide seeds the low half with the dividend; multiply starts at zero.
                    r_acc    <= w_is_div ? {{XLEN{1'b0}}, w_abs_a} : '0;
                    r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
                    r_y      <= w_abs_b;
                    r_cnt    <= '0;
                    r_sign_q <= w_is_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]);
                    r_sign_r <= w_is_signed & r_a[XLEN-1];
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_is_div) begin
                        if (!w_div_diff[XLEN]) begin
                            r_acc <= {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                        end else begin
                            r_acc <= {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (r_y[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_y     <= r_y >> 1;
                    end
                end
                S_FIXUP: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (w_is_div) begin
                            if (r_b == '0) begin
                                // Divide by zero: fixed result, no sign fix-up.
                                r_hi <= r_a;
                                r_lo <= '1;
                            end else begin
                                r_lo <= r_sign_q ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
                                r_hi <= r_sign_r ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
                            end
                        end else begin
                            {r_hi, r_lo} <= r_sign_q ? f_neg2(r_acc) : r_acc;
                        end
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the pipelined CPU's EX stage.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the HI/LO registers.
- Drives busy so the hazard logic stalls IF/ID/EX while an operation is in flight.
- Handles signed operands by magnitude conversion on entry and sign fix-up on exit.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required to work.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue an operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- flush  in  1  abort the in-flight operation (branch or exception squash)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  high in PREP, CALC and FIXUP
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides every other input, including mid-operation.
- States and transitions:
  - IDLE: start=1 latches op, a and b; next state PREP.
  - PREP: 1 cycle. For signed ops, take |a| and |b|; record sign_q = a[31]^b[31] and sign_r = a[31]. Clear the 64-bit accumulator. Next state CALC.
  - CALC: 32 cycles, one bit per cycle.
    - Multiply: if the multiplier LSB is 1, add the 64-bit left-shifted multiplicand to the product; then shift the multiplicand left and the multiplier right.
    - Divide: restoring division, shifting the remainder left by one and subtracting the divisor.
  - FIXUP: 1 cycle. Apply signs: negate the product if sign_q; negate the quotient if sign_q; negate the remainder if sign_r. Write HI/LO at the end of this cycle. Next state IDLE, with done=1 in the following cycle.
- Latency:
  - start high in cycle 0.
  - busy high in cycles 1..34.
  - done=1 and new hi/lo visible in cycle 35.
  - A new start is accepted in cycle 35.
- Results:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder. The remainder takes the dividend's sign.
- Divide by zero (b=0, DIV or DIVU): lo = 32'hFFFF_FFFF, hi = a, sign fix-up bypassed. Latency is unchanged.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo = 32'h8000_0000, hi = 0.
- start while busy: ignored; the in-flight operation is unaffected.
- flush: while busy, next state is IDLE, busy drops the next cycle, hi/lo are unchanged and no done pulse is produced. flush in IDLE has no effect. flush and start in the same IDLE cycle: the start is dropped.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; hi/lo take wdata on the next edge.
  - Ignored while busy, or when start is high in the same cycle.
  - Both enables high: both registers are written.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN
- Defined: for MULT/MULTU, CALC ends after the iteration that leaves the remaining multiplier at zero.
  - Number of CALC cycles = max(1, bit index of the highest set bit of |b| + 1).
  - done arrives at cycle 3 + CALC cycles.
  - Divide latency is unchanged.
- Undefined: CALC is always 32 cycles for every op.
- Results are identical in both builds.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> done at cycle 35, hi=32'hFFFF_FFFE, lo=32'h0000_0001; busy high in cycles 1..34.
- MULT a=-7, b=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. With MULDIV_EARLY_OUT_EN: CALC is 2 cycles and done arrives at cycle 5.
- DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0, with no hang or X.
- Abort and write rules:
  - Preload hi=32'h1111_1111 via MTHI, start MULTU 5*5, assert flush in cycle 10 -> busy=0 in cycle 11, no done, hi still 32'h1111_1111.
  - Then a fresh MULTU 5*5 -> lo=25.
  - hi_we pulsed while busy -> hi unchanged.
- Assert rst in cycle 20 of a DIVU -> all outputs 0 the next cycle; start on the following cycle completes normally.
